// File: rtl/ego1_dff_bank_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// ego1_pkg
// Shared types and constants for the EGO1 flip-flop lab bank sequencer.
//   seq_state_t : sequencer state (run / clear / preset)
//   SW_*        : bit positions within the 8-bit switch bus
//   LED_*       : field positions within the 16-bit LED bus
// ---------------------------------------------------------------------------
package ego1_pkg;

    localparam int SW_W  = 8;
    localparam int LED_W = 16;
    localparam int CNT_W = 6;

    typedef enum logic [1:0] {
        S_RUN = 2'd0,
        S_CLR = 2'd1,
        S_SET = 2'd2
    } seq_state_t;

    // Switch indices
    localparam int SW_D    = 0;
    localparam int SW_AUTO = 1;
    localparam int SW_RD_N = 6;
    localparam int SW_SD_N = 7;

    // LED field positions
    localparam int LED_Q_LSB   = 0;
    localparam int LED_STEP    = 8;
    localparam int LED_AUTO    = 9;
    localparam int LED_CNT_LSB = 10;

    // Synchronizer reset image: clear/preset inputs idle high (inactive),
    // everything else low, so nothing fires as reset is released.
    localparam logic [SW_W-1:0] SW_SYNC_RST = 8'hC0;

    // Clear has priority over preset; both idle high.
    function automatic seq_state_t decode_state(input logic rd_n, input logic sd_n);
        seq_state_t st;
        if (!rd_n) begin
            st = S_CLR;
        end else if (!sd_n) begin
            st = S_SET;
        end else begin
            st = S_RUN;
        end
        return st;
    endfunction

endpackage

// File: rtl/ego1_dff_bank_sequencer_if.sv
// ---------------------------------------------------------------------------
// ego1_dff_bank_sequencer_if
// Board pin bundle for the bank sequencer.
//   sw_pin  [7:0]  : slide switches (D, AUTO, RD_n, SD_n)
//   btn_1          : raw S1 pushbutton, active-high, bouncing
//   led_pin [15:0] : bank Q, step indicator, AUTO echo, step count
// master = board/stimulus side, slave = sequencer side.
// ---------------------------------------------------------------------------
interface ego1_dff_bank_sequencer_if;
    import ego1_pkg::*;

    logic [SW_W-1:0]  sw_pin;
    logic             btn_1;
    logic [LED_W-1:0] led_pin;

    modport master (
        output sw_pin,
        output btn_1,
        input  led_pin
    );

    modport slave (
        input  sw_pin,
        input  btn_1,
        output led_pin
    );

endinterface

// File: rtl/ego1_dff_bank_sequencer_debounce.sv
// ---------------------------------------------------------------------------
// ego1_debounce
// Two-flop synchronizer plus stability-counter debouncer for one button.
//   clk     : system clock
//   rst     : asynchronous active-high reset
//   btn_i   : raw (asynchronous, bouncing) button level
//   level_o : debounced level
//   press_o : one-cycle pulse on each 0->1 change of the debounced level
// The debounced level follows the synchronized input only after the two have
// differed for DB_CYCLES consecutive cycles; any agreement restarts the count.
// ---------------------------------------------------------------------------
module ego1_debounce #(
    parameter int DB_CYCLES = 2_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_i,
    output logic level_o,
    output logic press_o
);

    localparam int DB_W = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);

    logic [1:0]      sync_q;
    logic [DB_W-1:0] cnt_q, cnt_d;
    logic            level_q, level_d;
    logic            press_q, press_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q  <= 2'b00;
            cnt_q   <= '0;
            level_q <= 1'b0;
            press_q <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], btn_i};
            cnt_q   <= cnt_d;
            level_q <= level_d;
            press_q <= press_d;
        end
    end

    always_comb begin
        cnt_d   = '0;
        level_d = level_q;
        press_d = 1'b0;
        if (sync_q[1] != level_q) begin
            // The cycle that completes the run of DB_CYCLES differing samples
            // flips the level; press is registered alongside it.
            if (cnt_q == DB_LAST) begin
                level_d = sync_q[1];
                press_d = sync_q[1];
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    assign level_o = level_q;
    assign press_o = press_q;

endmodule

// File: rtl/ego1_dff_bank_sequencer.sv
// ---------------------------------------------------------------------------
// ego1_dff_bank_sequencer
// Sequences an 8-bit D flip-flop shift chain for the EGO1 lab board.
//   clk  : 100 MHz system clock
//   rst  : asynchronous active-high reset
//   pins : slave side of the board bundle
//          sw_pin[0] D, [1] AUTO, [6] RD_n (clear), [7] SD_n (preset)
//          btn_1 raw S1 step button
//          led_pin[7:0] bank, [8] step toggle, [9] AUTO echo, [15:10] count
// Steps come from the debounced button (AUTO=0) or a free-running prescaler
// (AUTO=1). Clear beats preset, and both discard any step in their cycle.
// ---------------------------------------------------------------------------
module ego1_dff_bank_sequencer
    import ego1_pkg::*;
#(
    parameter int DB_CYCLES = 2_000_000,
    parameter int AUTO_DIV  = 50_000_000
) (
    input  logic                      clk,
    input  logic                      rst,
    ego1_dff_bank_sequencer_if.slave  pins
);

    localparam int PRE_W = $clog2(AUTO_DIV);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(AUTO_DIV - 1);

    // ---------------- switch synchronizers ----------------
    logic [SW_W-1:0] sw_s1_q, sw_s2_q;

    for (genvar gi = 0; gi < SW_W; gi++) begin : g_sw_sync
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                sw_s1_q[gi] <= SW_SYNC_RST[gi];
                sw_s2_q[gi] <= SW_SYNC_RST[gi];
            end else begin
                sw_s1_q[gi] <= pins.sw_pin[gi];
                sw_s2_q[gi] <= sw_s1_q[gi];
            end
        end
    end

    logic d_s, auto_s, rd_n_s, sd_n_s;
    logic sw_unused;

    assign d_s    = sw_s2_q[SW_D];
    assign auto_s = sw_s2_q[SW_AUTO];
    assign rd_n_s = sw_s2_q[SW_RD_N];
    assign sd_n_s = sw_s2_q[SW_SD_N];
    assign sw_unused = &{1'b0, sw_s2_q[5:2]};

    // ---------------- button ----------------
    logic press;
    logic btn_level_unused;

    ego1_debounce #(
        .DB_CYCLES (DB_CYCLES)
    ) u_btn_db (
        .clk     (clk),
        .rst     (rst),
        .btn_i   (pins.btn_1),
        .level_o (btn_level_unused),
        .press_o (press)
    );

    // ---------------- state ----------------
    seq_state_t            state_q, state_d;
    logic [PRE_W-1:0]      presc_q, presc_d;
    logic [7:0]            bank_q, bank_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  step_led_q, step_led_d;
    logic                  auto_q;

    logic                  run_auto;
    logic                  tick;
    logic                  step;
    logic [7:0]            shifted;

    // Serial chain: D enters bit 0, every other stage takes its neighbour.
    for (genvar gi = 0; gi < 8; gi++) begin : g_chain
        if (gi == 0) begin : g_head
            assign shifted[gi] = d_s;
        end else begin : g_link
            assign shifted[gi] = bank_q[gi-1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_RUN;
            presc_q    <= '0;
            bank_q     <= 8'h00;
            cnt_q      <= '0;
            step_led_q <= 1'b0;
            auto_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            presc_q    <= presc_d;
            bank_q     <= bank_d;
            cnt_q      <= cnt_d;
            step_led_q <= step_led_d;
            auto_q     <= auto_s;
        end
    end

    // The state is re-decoded from the synchronized switches every cycle and
    // the bank acts on that decode directly, so a switch edge reaches the LEDs
    // after the two sync flops plus one bank register.
    always_comb begin
        state_d    = state_q;
        presc_d    = '0;
        bank_d     = bank_q;
        cnt_d      = cnt_q;
        step_led_d = step_led_q;

        state_d = decode_state(rd_n_s, sd_n_s);

        // Prescaler only runs in auto mode while in S_RUN; otherwise it sits
        // at zero so a fresh run always waits a full AUTO_DIV period.
        run_auto = auto_s && (state_d == S_RUN);
        tick     = run_auto && (presc_q == PRE_LAST);
        if (run_auto && !tick) begin
            presc_d = presc_q + 1'b1;
        end

        // In auto mode the button is ignored entirely.
        step = (state_d == S_RUN) && (auto_s ? tick : press);

        unique case (state_d)
            S_CLR: begin
                bank_d = 8'h00;
                cnt_d  = '0;
            end
            S_SET: begin
                bank_d = 8'hFF;
            end
            default: begin
                if (step) begin
                    bank_d     = shifted;
                    cnt_d      = cnt_q + 1'b1;
                    step_led_d = ~step_led_q;
                end
            end
        endcase
    end

    assign pins.led_pin[LED_Q_LSB +: 8]       = bank_q;
    assign pins.led_pin[LED_STEP]             = step_led_q;
    assign pins.led_pin[LED_AUTO]             = auto_q;
    assign pins.led_pin[LED_CNT_LSB +: CNT_W] = cnt_q;

endmodule

// File: tb/tb_ego1_dff_bank_sequencer.sv
module tb_ego1_dff_bank_sequencer;

    localparam int DB = 4;
    localparam int AD = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    ego1_dff_bank_sequencer_if pins ();

    ego1_dff_bank_sequencer #(
        .DB_CYCLES (DB),
        .AUTO_DIV  (AD)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .pins (pins)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model of what the LEDs should show
    logic [7:0] m_bank = 8'h00;
    logic [5:0] m_cnt  = 6'd0;
    logic       m_tog  = 1'b0;
    logic       m_auto = 1'b0;
    logic       m_d    = 1'b0;

    function automatic logic [15:0] m_led();
        return {m_cnt, m_auto, m_tog, m_bank};
    endfunction

    task automatic model_step();
        m_bank = {m_bank[6:0], m_d};
        m_cnt  = m_cnt + 6'd1;
        m_tog  = ~m_tog;
    endtask

    // Advance n rising edges, then sit 1 time unit past the last one.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        pins.sw_pin = 8'h3B;
        pins.btn_1  = 1'b0;
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick(1);
            n_cmp++;
            if (pins.led_pin !== 16'h0000) begin
                n_bad++;
                $display("FAIL reset_hold[%0d]: led=%h required 0000", i, pins.led_pin);
            end else $display("ok reset_hold[%0d]: led=%h", i, pins.led_pin);
        end
        rst = 1'b0;
        tick(1);
        n_cmp++;
        if (pins.led_pin !== 16'h0000) begin
            n_bad++;
            $display("FAIL reset_release: led=%h required 0000", pins.led_pin);
        end else $display("ok reset_release: led=%h", pins.led_pin);
    endtask

    task automatic test_clear_preset();
        // RD_n and SD_n both low: clear wins
        pins.sw_pin = 8'h00;
        m_auto = 1'b0;
        tick(3);
        m_bank = 8'h00;
        m_cnt  = 6'd0;
        n_cmp++;
        if (pins.led_pin !== 16'h0000) begin
            n_bad++;
            $display("FAIL clr_priority: led=%h required 0000", pins.led_pin);
        end else $display("ok clr_priority: led=%h", pins.led_pin);

        // Release clear, keep preset
        pins.sw_pin = 8'h40;
        tick(2);
        n_cmp++;
        if (pins.led_pin !== 16'h0000) begin
            n_bad++;
            $display("FAIL preset_latency: led=%h required 0000", pins.led_pin);
        end else $display("ok preset_latency: led=%h", pins.led_pin);
        tick(1);
        m_bank = 8'hFF;
        n_cmp++;
        if (pins.led_pin !== 16'h00FF) begin
            n_bad++;
            $display("FAIL preset: led=%h required 00ff", pins.led_pin);
        end else $display("ok preset: led=%h", pins.led_pin);
    endtask

    task automatic test_manual_shift();
        pins.sw_pin = 8'h81;     // clear, D=1
        tick(3);
        m_bank = 8'h00;
        m_d    = 1'b1;
        pins.sw_pin = 8'hC1;     // run, manual, D=1
        tick(3);
        n_cmp++;
        if (pins.led_pin !== m_led()) begin
            n_bad++;
            $display("FAIL manual_idle: led=%h required %h", pins.led_pin, m_led());
        end else $display("ok manual_idle: led=%h", pins.led_pin);

        for (int p = 0; p < 3; p++) begin
            pins.btn_1 = 1'b1;
            tick(6);
            n_cmp++;
            if (pins.led_pin !== m_led()) begin
                n_bad++;
                $display("FAIL press%0d_early: led=%h required %h", p, pins.led_pin, m_led());
            end else $display("ok press%0d_early: led=%h", p, pins.led_pin);
            tick(1);
            model_step();
            n_cmp++;
            if (pins.led_pin !== m_led()) begin
                n_bad++;
                $display("FAIL press%0d_step: led=%h required %h", p, pins.led_pin, m_led());
            end else $display("ok press%0d_step: led=%h", p, pins.led_pin);
            tick(3);
            pins.btn_1 = 1'b0;
            tick(10);
        end
        n_cmp++;
        if (pins.led_pin !== 16'h0D07) begin
            n_bad++;
            $display("FAIL manual_total: led=%h required 0d07", pins.led_pin);
        end else $display("ok manual_total: led=%h", pins.led_pin);
    endtask

    task automatic test_bounce();
        for (int i = 0; i < 5; i++) begin
            pins.btn_1 = 1'b1;
            tick(2);
            pins.btn_1 = 1'b0;
            tick(2);
        end
        n_cmp++;
        if (pins.led_pin !== m_led()) begin
            n_bad++;
            $display("FAIL bounce_reject: led=%h required %h", pins.led_pin, m_led());
        end else $display("ok bounce_reject: led=%h", pins.led_pin);

        pins.btn_1 = 1'b1;
        tick(6);
        n_cmp++;
        if (pins.led_pin !== m_led()) begin
            n_bad++;
            $display("FAIL bounce_early: led=%h required %h", pins.led_pin, m_led());
        end else $display("ok bounce_early: led=%h", pins.led_pin);
        tick(1);
        model_step();
        n_cmp++;
        if (pins.led_pin !== 16'h100F) begin
            n_bad++;
            $display("FAIL bounce_step: led=%h required 100f", pins.led_pin);
        end else $display("ok bounce_step: led=%h", pins.led_pin);
        tick(5);
        pins.btn_1 = 1'b0;
        tick(10);
        n_cmp++;
        if (pins.led_pin !== m_led()) begin
            n_bad++;
            $display("FAIL bounce_single: led=%h required %h", pins.led_pin, m_led());
        end else $display("ok bounce_single: led=%h", pins.led_pin);
    endtask

    task automatic test_auto();
        pins.sw_pin = 8'h42;     // preset, AUTO=1, D=0
        tick(5);
        m_auto = 1'b1;
        m_bank = 8'hFF;
        m_d    = 1'b0;
        n_cmp++;
        if (pins.led_pin !== 16'h12FF) begin
            n_bad++;
            $display("FAIL auto_preset: led=%h required 12ff", pins.led_pin);
        end else $display("ok auto_preset: led=%h", pins.led_pin);

        pins.sw_pin = 8'hC2;     // run
        for (int i = 0; i < 6; i++) begin
            if (i == 3) pins.btn_1 = 1'b1;   // press must be ignored in auto
            tick((i == 0) ? 9 : 7);
            n_cmp++;
            if (pins.led_pin !== m_led()) begin
                n_bad++;
                $display("FAIL auto%0d_early: led=%h required %h", i, pins.led_pin, m_led());
            end else $display("ok auto%0d_early: led=%h", i, pins.led_pin);
            tick(1);
            model_step();
            n_cmp++;
            if (pins.led_pin !== m_led()) begin
                n_bad++;
                $display("FAIL auto%0d_step: led=%h required %h", i, pins.led_pin, m_led());
            end else $display("ok auto%0d_step: led=%h", i, pins.led_pin);
        end
        pins.btn_1 = 1'b0;
    endtask

    task automatic test_wrap_clear();
        tick(3);
        pins.sw_pin = 8'h82;     // clear mid-period, AUTO stays 1
        tick(3);
        m_bank = 8'h00;
        m_cnt  = 6'd0;
        n_cmp++;
        if (pins.led_pin !== m_led()) begin
            n_bad++;
            $display("FAIL midrun_clear: led=%h required %h", pins.led_pin, m_led());
        end else $display("ok midrun_clear: led=%h", pins.led_pin);
        tick(1);
        pins.sw_pin = 8'hC3;     // release, D=1
        m_d = 1'b1;
        tick(9);
        n_cmp++;
        if (pins.led_pin !== m_led()) begin
            n_bad++;
            $display("FAIL restart_early: led=%h required %h", pins.led_pin, m_led());
        end else $display("ok restart_early: led=%h", pins.led_pin);
        tick(1);
        model_step();
        n_cmp++;
        if (pins.led_pin !== m_led()) begin
            n_bad++;
            $display("FAIL restart_step: led=%h required %h", pins.led_pin, m_led());
        end else $display("ok restart_step: led=%h", pins.led_pin);

        for (int i = 1; i < 64; i++) begin
            tick(8);
            model_step();
            n_cmp++;
            if (pins.led_pin !== m_led()) begin
                n_bad++;
                $display("FAIL wrap_step%0d: led=%h required %h", i, pins.led_pin, m_led());
            end else $display("ok wrap_step%0d: led=%h", i, pins.led_pin);
        end
        n_cmp++;
        if (pins.led_pin[15:8] !== 8'h02 || pins.led_pin[7:0] !== 8'hFF) begin
            n_bad++;
            $display("FAIL wrap_count: led=%h required 02ff", pins.led_pin);
        end else $display("ok wrap_count: led=%h", pins.led_pin);
    endtask

    task automatic test_reset_mid();
        tick(3);                 // partway through a prescale period
        rst = 1'b1;
        #1;
        m_bank = 8'h00;
        m_cnt  = 6'd0;
        m_tog  = 1'b0;
        m_auto = 1'b0;
        n_cmp++;
        if (pins.led_pin !== 16'h0000) begin
            n_bad++;
            $display("FAIL async_reset: led=%h required 0000", pins.led_pin);
        end else $display("ok async_reset: led=%h", pins.led_pin);
        tick(2);
        rst = 1'b0;
        tick(1);
        n_cmp++;
        if (pins.led_pin !== 16'h0000) begin
            n_bad++;
            $display("FAIL no_step_on_release: led=%h required 0000", pins.led_pin);
        end else $display("ok no_step_on_release: led=%h", pins.led_pin);
        tick(8);
        m_auto = 1'b1;
        n_cmp++;
        if (pins.led_pin !== 16'h0200) begin
            n_bad++;
            $display("FAIL post_reset_early: led=%h required 0200", pins.led_pin);
        end else $display("ok post_reset_early: led=%h", pins.led_pin);
        tick(1);
        model_step();
        n_cmp++;
        if (pins.led_pin !== 16'h0701) begin
            n_bad++;
            $display("FAIL post_reset_step: led=%h required 0701", pins.led_pin);
        end else $display("ok post_reset_step: led=%h", pins.led_pin);
    endtask

    initial begin
        pins.sw_pin = 8'h3B;
        pins.btn_1  = 1'b0;
        test_reset();
        test_clear_preset();
        test_manual_shift();
        test_bounce();
        test_auto();
        test_wrap_clear();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
